fetch_sequencer: RTL and testbench

- Control FSM that sequences instruction fetch for the 16-bit core.
- Owns the program counter and drives the memory read handshake.
- Drives the active-low load strobe of the instruction register (IR); instruction memory data is wired straight to the IR input.
- Decodes the IR opcode to detect HALT, then hands each instruction to the execute unit through a start/done handshake.

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: run control, instruction-memory read handshake,
// IR load/opcode, execute-unit handshake, jump request and status.
interface fetch_sequencer_if;
    logic        run;
    logic        memReq;
    logic        memAck;
    logic [15:0] memAddr;
    logic        irNotLoad;
    logic [6:0]  irOpcode;
    logic        execStart;
    logic        execDone;
    logic        pcLoad;
    logic [15:0] pcIn;
    logic [15:0] pc;
    logic        halted;
    logic        busError;
    logic [2:0]  state;

    // Sequencer side
    modport master (
        input  run, memAck, irOpcode, execDone, pcLoad, pcIn,
        output memReq, memAddr, irNotLoad, execStart, pc, halted, busError, state
    );

    // Environment side: memory, IR, execute unit, core control
    modport slave (
        output run, memAck, irOpcode, execDone, pcLoad, pcIn,
        input  memReq, memAddr, irNotLoad, execStart, pc, halted, busError, state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the 16-bit core: owns the PC, runs the
// memory read handshake, strobes the IR, detects HALT and hands each
// instruction to the execute unit.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [6:0]  HALT_OPCODE  = 7'h7F,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } state_t;

    // Counter value during the last tolerated no-ack FETCH cycle
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        first_q, first_d;     // first EXEC cycle of this instruction
    logic        halted_q, halted_d;
    logic        berr_q, berr_d;
    logic        mem_req, ir_n_load, exec_start;

    // State, PC, timeout counter and status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_VECTOR;
            cnt_q    <= 8'd0;
            first_q  <= 1'b0;
            halted_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            halted_q <= halted_d;
            berr_q   <= berr_d;
        end
    end

    // Next-state logic and decoded strobes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        first_d    = 1'b0;
        mem_req    = 1'b0;
        ir_n_load  = 1'b1;
        exec_start = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (bus.run) state_d = FETCH;
            end
            FETCH: begin
                mem_req   = 1'b1;
                // IR captures memory data on the same edge the ack is seen
                ir_n_load = ~bus.memAck;
                if (bus.memAck) begin
                    pc_d    = pc_q + 16'd1;
                    cnt_d   = 8'd0;
                    state_d = DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DECODE: begin
                if (bus.irOpcode == HALT_OPCODE) begin
                    state_d = HALTED;
                end else begin
                    state_d = EXEC;
                    first_d = 1'b1;
                end
            end
            EXEC: begin
                exec_start = first_q;
                // A jump taken together with done still steers the next fetch
                if (bus.pcLoad) pc_d = bus.pcIn;
                if (bus.execDone) state_d = bus.run ? FETCH : IDLE;
            end
            HALTED: state_d = HALTED;
            FAULT:  state_d = FAULT;
            default: state_d = IDLE;
        endcase
        halted_d = (state_d == HALTED);
        berr_d   = (state_d == FAULT);
    end

    assign bus.memReq    = mem_req;
    assign bus.memAddr   = pc_q;
    assign bus.irNotLoad = ir_n_load;
    assign bus.execStart = exec_start;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.busError  = berr_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: reactive memory / execute-unit responders,
// an instruction-level reference model checked every cycle, and literal
// expectations along the directed scenario.
module tb_fetch_sequencer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_VECTOR(16'h0000), .HALT_OPCODE(7'h7F), .TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    // Stimulus knobs
    logic        run;
    int          ack_dly, done_dly, pl_mode;
    bit          ack_en, ack_force, halt_en;
    logic [15:0] pl_target, halt_addr;

    int          fcnt = 0;
    int          ecnt = 0;
    logic [15:0] ir   = 16'h0000;
    logic [15:0] memData;

    // Memory holds 0A49 everywhere except an optional HALT word
    assign memData       = (halt_en && bus.memAddr == halt_addr) ? 16'hFE00 : 16'h0A49;
    assign bus.run       = run;
    assign bus.memAck    = ack_force | (bus.memReq & ack_en & (fcnt >= ack_dly));
    assign bus.execDone  = (bus.state == 3'd3) && (ecnt >= done_dly);
    assign bus.pcLoad    = (pl_mode == 1 && bus.state == 3'd3 && bus.execDone) ||
                           (pl_mode == 2 && bus.state == 3'd2);
    assign bus.pcIn      = pl_target;
    assign bus.irOpcode  = ir[15:9];

    // Responder counters and the instruction register
    always @(posedge clock) begin
        fcnt <= (bus.memReq && !bus.memAck) ? fcnt + 1 : 0;
        ecnt <= (bus.state == 3'd3) ? ecnt + 1 : 0;
        if (!bus.irNotLoad) ir <= memData;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one instruction walks idle -> fetch -> decode -> exec
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALT = 4, P_FAULT = 5;
    int          m_ph    = P_IDLE;
    logic [15:0] m_pc    = 16'h0000;
    int          m_wait  = 0;
    bit          m_first = 0;
    bit          m_halt  = 0;
    bit          m_berr  = 0;
    bit          m_is_halt = 0;
    logic [15:0] m_word;

    always @(negedge clock) begin
        if (reset) begin
            m_ph = P_IDLE; m_pc = 16'h0000; m_wait = 0;
            m_first = 0; m_halt = 0; m_berr = 0;
        end
        chk("state",     {29'd0, bus.state},     m_ph);
        chk("memReq",    {31'd0, bus.memReq},    {31'd0, m_ph == P_FETCH});
        chk("irNotLoad", {31'd0, bus.irNotLoad}, {31'd0, !(m_ph == P_FETCH && bus.memAck)});
        chk("execStart", {31'd0, bus.execStart}, {31'd0, m_ph == P_EXEC && m_first});
        chk("memAddr",   {16'd0, bus.memAddr},   {16'd0, m_pc});
        chk("pc",        {16'd0, bus.pc},        {16'd0, m_pc});
        chk("halted",    {31'd0, bus.halted},    {31'd0, m_halt});
        chk("busError",  {31'd0, bus.busError},  {31'd0, m_berr});
        if (!reset) begin
            case (m_ph)
                P_IDLE: if (run) m_ph = P_FETCH;
                P_FETCH: begin
                    if (bus.memAck) begin
                        m_word    = (halt_en && m_pc == halt_addr) ? 16'hFE00 : 16'h0A49;
                        m_is_halt = (m_word[15:9] == 7'h7F);
                        m_pc      = m_pc + 16'd1;
                        m_wait    = 0;
                        m_ph      = P_DECODE;
                    end else begin
                        m_wait++;
                        if (m_wait == 16) begin m_ph = P_FAULT; m_berr = 1; end
                    end
                end
                P_DECODE: begin
                    if (m_is_halt) begin m_ph = P_HALT; m_halt = 1; end
                    else begin m_ph = P_EXEC; m_first = 1; end
                end
                P_EXEC: begin
                    m_first = 0;
                    if (bus.pcLoad) m_pc = bus.pcIn;
                    if (bus.execDone) m_ph = run ? P_FETCH : P_IDLE;
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0;
        ack_dly = 0; ack_en = 1; ack_force = 0; done_dly = 0;
        pl_mode = 0; pl_target = 16'h0000; halt_addr = 16'h0000; halt_en = 0;
        tick();
        chk("rst_state",     {29'd0, bus.state},     0);
        chk("rst_pc",        {16'd0, bus.pc},        0);
        chk("rst_memReq",    {31'd0, bus.memReq},    0);
        chk("rst_irNotLoad", {31'd0, bus.irNotLoad}, 1);
        chk("rst_halted",    {31'd0, bus.halted},    0);
        chk("rst_busError",  {31'd0, bus.busError},  0);
        reset = 1'b0; run = 1'b1;

        // Back-to-back instructions with immediate ack and done
        tick();
        chk("t1_fetch",   {29'd0, bus.state},     1);
        chk("t1_addr0",   {16'd0, bus.memAddr},   16'h0000);
        chk("t1_irload",  {31'd0, bus.irNotLoad}, 0);
        tick();
        chk("t1_pc1",     {16'd0, bus.pc},        16'h0001);
        chk("t1_irhold",  {31'd0, bus.irNotLoad}, 1);
        chk("t1_opcode",  {25'd0, bus.irOpcode},  7'h05);
        tick();
        chk("t1_start",   {31'd0, bus.execStart}, 1);
        tick();
        chk("t1_period",  {29'd0, bus.state},     1);
        chk("t1_addr1",   {16'd0, bus.memAddr},   16'h0001);
        chk("t1_pulse",   {31'd0, bus.execStart}, 0);

        // Ack delayed by 5 cycles
        ack_dly = 5;
        repeat (5) tick();
        chk("t2_req",     {31'd0, bus.memReq},    1);
        chk("t2_addr",    {16'd0, bus.memAddr},   16'h0001);
        chk("t2_pchold",  {16'd0, bus.pc},        16'h0001);
        chk("t2_irload",  {31'd0, bus.irNotLoad}, 0);
        tick();
        chk("t2_pc_once", {16'd0, bus.pc},        16'h0002);
        chk("t2_noerr",   {31'd0, bus.busError},  0);

        // Jump taken together with done; jump during DECODE ignored
        ack_dly = 0; pl_mode = 1; pl_target = 16'h1234;
        tick();
        tick();
        chk("t4_jump",    {16'd0, bus.memAddr},   16'h1234);
        pl_mode = 2; pl_target = 16'h5555;
        tick();
        tick();
        chk("t4_dec_ign", {16'd0, bus.pc},        16'h1235);
        pl_mode = 0;
        tick();
        chk("t4_next",    {16'd0, bus.memAddr},   16'h1235);

        // PC wrap at FFFF, then HALT word at 0000
        pl_mode = 1; pl_target = 16'hFFFF;
        tick();
        tick();
        tick();
        chk("t5_ffff",    {16'd0, bus.memAddr},   16'hFFFF);
        pl_mode = 0; halt_en = 1; halt_addr = 16'h0000;
        tick();
        chk("t5_wrap",    {16'd0, bus.pc},        16'h0000);
        tick();
        tick();
        chk("t5_addr0",   {16'd0, bus.memAddr},   16'h0000);
        tick();
        chk("t5_haltop",  {25'd0, bus.irOpcode},  7'h7F);
        tick();
        chk("t5_halted",  {31'd0, bus.halted},    1);
        chk("t5_state",   {29'd0, bus.state},     4);
        chk("t5_nostart", {31'd0, bus.execStart}, 0);
        repeat (3) tick();
        chk("t5_noreq",   {31'd0, bus.memReq},    0);
        chk("t5_stay",    {29'd0, bus.state},     4);
        reset = 1'b1; halt_en = 0;
        tick();
        chk("t5_rst",     {31'd0, bus.halted},    0);

        // Fetch timeout
        reset = 1'b0; ack_en = 0;
        tick();
        repeat (15) tick();
        chk("t3_c16",     {29'd0, bus.state},     1);
        chk("t3_c16err",  {31'd0, bus.busError},  0);
        tick();
        chk("t3_fault",   {29'd0, bus.state},     5);
        chk("t3_berr",    {31'd0, bus.busError},  1);
        chk("t3_noreq",   {31'd0, bus.memReq},    0);
        ack_force = 1;
        tick();
        chk("t3_lateack", {29'd0, bus.state},     5);
        chk("t3_pc",      {16'd0, bus.pc},        16'h0000);
        ack_force = 0; ack_en = 1; reset = 1'b1;
        tick();
        chk("t3_rst_err", {31'd0, bus.busError},  0);
        chk("t3_rst_pc",  {16'd0, bus.pc},        16'h0000);
        reset = 1'b0;

        // run dropped mid-fetch, then async reset mid-exec
        tick();
        ack_dly = 2; run = 1'b0;
        tick();
        tick();
        chk("t6_ack",     {31'd0, bus.irNotLoad}, 0);
        tick();
        tick();
        chk("t6_exec",    {29'd0, bus.state},     3);
        tick();
        chk("t6_idle",    {29'd0, bus.state},     0);
        chk("t6_pc",      {16'd0, bus.pc},        16'h0001);
        ack_dly = 0; run = 1'b1; done_dly = 3;
        tick();
        tick();
        tick();
        chk("t6_start",   {31'd0, bus.execStart}, 1);
        tick();
        chk("t6_wait",    {31'd0, bus.execStart}, 0);
        #2 reset = 1'b1;
        #1;
        chk("t6_ar_state", {29'd0, bus.state},     0);
        chk("t6_ar_pc",    {16'd0, bus.pc},        16'h0000);
        chk("t6_ar_start", {31'd0, bus.execStart}, 0);
        chk("t6_ar_ir",    {31'd0, bus.irNotLoad}, 1);
        chk("t6_ar_req",   {31'd0, bus.memReq},    0);
        tick();
        reset = 1'b0; run = 1'b0; done_dly = 0;
        repeat (2) tick();
        chk("t6_end_idle", {29'd0, bus.state},     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
